// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory port, redirect input and the
// decode-facing valid/ready queue head. The master side is the fetch stage.
interface instruction_fetch_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic        misalign_fault;

  modport master (
    output imem_addr,
    input  imem_data,
    input  redirect_valid,
    input  redirect_target,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc,
    output out_pc_plus4,
    output misalign_fault
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    output redirect_valid,
    output redirect_target,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc,
    input  out_pc_plus4,
    input  misalign_fault
  );
endinterface

// File: rtl/instruction_fetch.sv
// MIPS fetch stage: owns the PC, captures {pc, word} into a FWFT queue for decode.
// Optional J-instruction predecode is enabled with `define FETCH_JUMP_PREDECODE_EN.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC    = 32'd0,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  instruction_fetch_if.master   bus_io
);

  localparam int              PTR_W   = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int              CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [31:0]      pc_q,       pc_d;
  logic [CNT_W-1:0] count_q,    count_d;
  logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
  logic             misalign_q, misalign_d;

  logic [31:0] q_pc_q    [QUEUE_DEPTH];
  logic [31:0] q_instr_q [QUEUE_DEPTH];

  logic        out_valid;
  logic        pop;
  logic        push;
  logic [31:0] pc_plus4;
  logic [31:0] redirect_pc;

  assign out_valid   = (count_q != '0);
  assign pop         = out_valid & bus_io.out_ready;
  assign push        = !bus_io.redirect_valid && ((count_q < DEPTH_C) || pop);
  assign pc_plus4    = pc_q + 32'd4;
  assign redirect_pc = {bus_io.redirect_target[31:2], 2'b00};

`ifdef FETCH_JUMP_PREDECODE_EN
  logic        is_jump;
  logic [31:0] jump_pc;
  assign is_jump = (bus_io.imem_data[31:26] == 6'b000010);
  assign jump_pc = {pc_plus4[31:28], bus_io.imem_data[25:0], 2'b00};
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    pc_d       = pc_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    misalign_d = misalign_q | (bus_io.redirect_valid & (|bus_io.redirect_target[1:0]));

    if (bus_io.redirect_valid) begin
      // A head popped this cycle was taken by decode; the flush drops the rest.
      pc_d     = redirect_pc;
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
`ifdef FETCH_JUMP_PREDECODE_EN
        pc_d     = is_jump ? jump_pc : pc_plus4;
`else
        pc_d     = pc_plus4;
`endif
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      misalign_q <= misalign_d;
    end
  end

  // NOTE: queue storage is deliberately not reset; entries are only observable
  // through out_valid, and the outputs are forced to zero while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc_q[wr_ptr_q]    <= pc_q;
      q_instr_q[wr_ptr_q] <= bus_io.imem_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  logic [31:0] head_pc;
  logic [31:0] head_instr;

  assign head_pc    = q_pc_q[rd_ptr_q];
  assign head_instr = q_instr_q[rd_ptr_q];

  assign bus_io.imem_addr      = pc_q;
  assign bus_io.out_valid      = out_valid;
  assign bus_io.out_pc         = out_valid ? head_pc : 32'd0;
  assign bus_io.out_instr      = out_valid ? head_instr : 32'd0;
  assign bus_io.out_pc_plus4   = out_valid ? (head_pc + 32'd4) : 32'd0;
  assign bus_io.misalign_fault = misalign_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed testbench for instruction_fetch: sequential fetch, stall, redirect,
// misalignment, PC wrap, zero word, asynchronous reset and J predecode.
module tb_instruction_fetch;

  logic clk;
  logic rst_n;
  logic jump_word_en;
  int   n_checks;
  int   n_errors;

  instruction_fetch_if bus ();
  instruction_fetch_if bus_wrap ();

  instruction_fetch #(.RESET_PC(32'd0), .QUEUE_DEPTH(2)) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus.master)
  );

  instruction_fetch #(.RESET_PC(32'hFFFF_FFFC), .QUEUE_DEPTH(2)) u_wrap (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus_wrap.master)
  );

  // Instruction memory image: tagged words, a zero word at 0x200, optional J at 16.
  function automatic logic [31:0] mem_word(input logic [31:0] addr, input logic jmp);
    if (jmp && addr == 32'd16) return {6'b000010, 26'd1};
    if (addr == 32'h0000_0200) return 32'd0;
    return {8'hA5, addr[23:0]};
  endfunction

  assign bus.imem_data      = mem_word(bus.imem_addr, jump_word_en);
  assign bus_wrap.imem_data = mem_word(bus_wrap.imem_addr, 1'b0);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n                 = 1'b0;
    jump_word_en          = 1'b0;
    bus.out_ready         = 1'b0;
    bus.redirect_valid    = 1'b0;
    bus.redirect_target   = 32'd0;
    bus_wrap.out_ready    = 1'b1;
    bus_wrap.redirect_valid  = 1'b0;
    bus_wrap.redirect_target = 32'd0;
    #2;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_errors++; $display("FAIL reset_valid: got %b expected 0", bus.out_valid);
    end
    n_checks++;
    if (bus.imem_addr !== 32'd0) begin
      n_errors++; $display("FAIL reset_addr: got %h expected 00000000", bus.imem_addr);
    end
    n_checks++;
    if ({bus.out_pc, bus.out_instr, bus.out_pc_plus4} !== 96'd0) begin
      n_errors++; $display("FAIL reset_outs: got %h %h %h expected zeros",
                           bus.out_pc, bus.out_instr, bus.out_pc_plus4);
    end
    n_checks++;
    if (bus.misalign_fault !== 1'b0) begin
      n_errors++; $display("FAIL reset_fault: got %b expected 0", bus.misalign_fault);
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_sequential();
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'(4 * i)) begin
        n_errors++; $display("FAIL seq_pc[%0d]: got valid=%b pc=%h expected valid=1 pc=%h",
                             i, bus.out_valid, bus.out_pc, 32'(4 * i));
      end
      n_checks++;
      if (bus.out_pc_plus4 !== 32'(4 * i + 4)) begin
        n_errors++; $display("FAIL seq_pc4[%0d]: got %h expected %h",
                             i, bus.out_pc_plus4, 32'(4 * i + 4));
      end
      n_checks++;
      if (bus.out_instr !== {8'hA5, 24'(4 * i)}) begin
        n_errors++; $display("FAIL seq_instr[%0d]: got %h expected %h",
                             i, bus.out_instr, {8'hA5, 24'(4 * i)});
      end
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_stall();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'd4; exp_pc[1] = 32'd8; exp_pc[2] = 32'd12;
    do_reset();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    n_checks++;
    if (bus.imem_addr !== 32'd8) begin
      n_errors++; $display("FAIL stall_addr: got %h expected 00000008", bus.imem_addr);
    end
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'd0) begin
      n_errors++; $display("FAIL stall_head: got valid=%b pc=%h expected valid=1 pc=0",
                           bus.out_valid, bus.out_pc);
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== exp_pc[i]) begin
        n_errors++; $display("FAIL stall_release[%0d]: got valid=%b pc=%h expected valid=1 pc=%h",
                             i, bus.out_valid, bus.out_pc, exp_pc[i]);
      end
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_redirect();
    do_reset();
    bus.out_ready = 1'b0;
    tick();
    tick();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    n_checks++;
    if (bus.out_pc !== 32'd4) begin
      n_errors++; $display("FAIL redir_pre_head: got %h expected 00000004", bus.out_pc);
    end
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h40;
    tick();
    bus.redirect_valid = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.imem_addr !== 32'h40) begin
      n_errors++; $display("FAIL redir_flush: got valid=%b addr=%h expected valid=0 addr=00000040",
                           bus.out_valid, bus.imem_addr);
    end
    n_checks++;
    if (bus.out_pc !== 32'd0) begin
      n_errors++; $display("FAIL redir_empty_pc: got %h expected 00000000", bus.out_pc);
    end
    bus.out_ready = 1'b1;
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h40 || bus.out_instr !== 32'hA500_0040) begin
      n_errors++; $display("FAIL redir_target: got valid=%b pc=%h instr=%h expected 1 00000040 a5000040",
                           bus.out_valid, bus.out_pc, bus.out_instr);
    end
    tick();
    n_checks++;
    if (bus.out_pc !== 32'h44) begin
      n_errors++; $display("FAIL redir_next: got %h expected 00000044", bus.out_pc);
    end
    n_checks++;
    if (bus.misalign_fault !== 1'b0) begin
      n_errors++; $display("FAIL redir_no_fault: got %b expected 0", bus.misalign_fault);
    end
  endtask

  task automatic test_misalign();
    bus.out_ready       = 1'b1;
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h42;
    tick();
    bus.redirect_valid = 1'b0;
    n_checks++;
    if (bus.misalign_fault !== 1'b1 || bus.imem_addr !== 32'h40 || bus.out_valid !== 1'b0) begin
      n_errors++; $display("FAIL misalign_set: got fault=%b addr=%h valid=%b expected 1 00000040 0",
                           bus.misalign_fault, bus.imem_addr, bus.out_valid);
    end
    tick();
    n_checks++;
    if (bus.out_pc !== 32'h40 || bus.misalign_fault !== 1'b1) begin
      n_errors++; $display("FAIL misalign_head: got pc=%h fault=%b expected 00000040 1",
                           bus.out_pc, bus.misalign_fault);
    end
    // Back-to-back aligned redirects: the last target wins, fault stays sticky.
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h100;
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.imem_addr !== 32'h100 || bus.misalign_fault !== 1'b1) begin
      n_errors++; $display("FAIL b2b_first: got valid=%b addr=%h fault=%b expected 0 00000100 1",
                           bus.out_valid, bus.imem_addr, bus.misalign_fault);
    end
    bus.redirect_target = 32'h200;
    tick();
    bus.redirect_valid = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.imem_addr !== 32'h200) begin
      n_errors++; $display("FAIL b2b_second: got valid=%b addr=%h expected 0 00000200",
                           bus.out_valid, bus.imem_addr);
    end
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h200 || bus.out_instr !== 32'd0) begin
      n_errors++; $display("FAIL zero_word: got valid=%b pc=%h instr=%h expected 1 00000200 00000000",
                           bus.out_valid, bus.out_pc, bus.out_instr);
    end
    tick();
    n_checks++;
    if (bus.out_pc !== 32'h204 || bus.misalign_fault !== 1'b1) begin
      n_errors++; $display("FAIL after_zero: got pc=%h fault=%b expected 00000204 1",
                           bus.out_pc, bus.misalign_fault);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.misalign_fault !== 1'b0) begin
      n_errors++; $display("FAIL fault_clear: got %b expected 0", bus.misalign_fault);
    end
    tick();
    rst_n = 1'b1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.out_ready = 1'b0;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.imem_addr !== 32'd0 || bus.out_pc !== 32'd0) begin
      n_errors++; $display("FAIL async_reset: got valid=%b addr=%h pc=%h expected 0 00000000 00000000",
                           bus.out_valid, bus.imem_addr, bus.out_pc);
    end
    tick();
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'd0 || bus.imem_addr !== 32'd4) begin
      n_errors++; $display("FAIL async_resume: got valid=%b pc=%h addr=%h expected 1 00000000 00000004",
                           bus.out_valid, bus.out_pc, bus.imem_addr);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    tick();
    n_checks++;
    if (bus_wrap.out_valid !== 1'b1 || bus_wrap.out_pc !== 32'hFFFF_FFFC ||
        bus_wrap.out_pc_plus4 !== 32'd0) begin
      n_errors++; $display("FAIL wrap_first: got valid=%b pc=%h pc4=%h expected 1 fffffffc 00000000",
                           bus_wrap.out_valid, bus_wrap.out_pc, bus_wrap.out_pc_plus4);
    end
    n_checks++;
    if (bus_wrap.imem_addr !== 32'd0) begin
      n_errors++; $display("FAIL wrap_addr: got %h expected 00000000", bus_wrap.imem_addr);
    end
    tick();
    n_checks++;
    if (bus_wrap.out_pc !== 32'd0 || bus_wrap.out_pc_plus4 !== 32'd4) begin
      n_errors++; $display("FAIL wrap_second: got pc=%h pc4=%h expected 00000000 00000004",
                           bus_wrap.out_pc, bus_wrap.out_pc_plus4);
    end
  endtask

  task automatic test_jump();
    logic [31:0] exp_after;
`ifdef FETCH_JUMP_PREDECODE_EN
    exp_after = 32'd4;
`else
    exp_after = 32'd20;
`endif
    jump_word_en = 1'b1;
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    n_checks++;
    if (bus.out_pc !== 32'd16 || bus.out_instr !== {6'b000010, 26'd1} ||
        bus.out_pc_plus4 !== 32'd20) begin
      n_errors++; $display("FAIL jump_word: got pc=%h instr=%h pc4=%h expected 00000010 08000001 00000014",
                           bus.out_pc, bus.out_instr, bus.out_pc_plus4);
    end
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== exp_after) begin
      n_errors++; $display("FAIL jump_next: got valid=%b pc=%h expected 1 %h",
                           bus.out_valid, bus.out_pc, exp_after);
    end
    bus.out_ready = 1'b0;
    jump_word_en  = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_misalign();
    test_async_reset();
    test_wrap();
    test_jump();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage directly upstream of the instruction memory; owns the program counter and drives the memory address continuously.
- Captures the returned 32-bit MIPS word, together with its PC, into a small first-word-fall-through queue.
- Decode consumes the queue through a valid/ready handshake.
- Accepts redirects (taken branch/jump from execute) that flush the queue and reload the PC.

Parameters:
- RESET_PC, 32'd0, PC value loaded on reset; must be a multiple of 4.
- QUEUE_DEPTH, 2, number of fetched entries buffered; power of two, 2..8.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- imem_addr  output  32  byte address to instruction memory; equals PC register, combinational.
- imem_data  input  32  instruction word returned combinationally for imem_addr in the same cycle.
- redirect_valid  input  1  flush and reload PC this cycle.
- redirect_target  input  32  new PC when redirect_valid=1.
- out_valid  output  1  queue head is valid.
- out_ready  input  1  decode accepts head this cycle.
- out_instr  output  32  head instruction word.
- out_pc  output  32  head instruction address.
- out_pc_plus4  output  32  out_pc+4, modulo 2^32.
- misalign_fault  output  1  sticky: a redirect target had bits [1:0] != 0.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - pc=RESET_PC, queue count=0, read/write pointers=0, misalign_fault=0.
  - out_valid=0; out_instr, out_pc and out_pc_plus4 read 0 while empty.
- pop = out_valid & out_ready.
- push = !redirect_valid & (count<QUEUE_DEPTH | pop).
- On push:
  - entry {pc, imem_data} written at tail.
  - pc <= pc+4, wrapping 32'hFFFFFFFC -> 0 (see Optional Feature for the jump case).
- No push: pc holds; imem_addr stable.
- Queue behaviour:
  - FWFT: outputs always show the head entry.
  - out_valid = (count!=0).
  - Push and pop in the same cycle: count unchanged; allowed even when full.
- Latency: word fetched at edge N is visible at outputs after edge N. Back-to-back throughput is one instruction per cycle with out_ready=1.
- First out_valid after reset release: after the first rising edge (PC=RESET_PC).
- Redirect (redirect_valid=1):
  - Has priority over push and pop.
  - Queue flushed: count=0, pointers=0. A head accepted the same cycle counts as consumed by decode; it is not re-presented.
  - pc <= {redirect_target[31:2], 2'b00}; no push that cycle.
  - Next cycle: out_valid=0, imem_addr=new PC. Cycle after: out_valid=1, out_pc=new PC.
- Misaligned target (redirect_target[1:0]!=0):
  - Address is aligned as above.
  - misalign_fault set to 1; cleared only by reset.
- Back-to-back redirects: the last one wins; queue stays empty.
- imem_data is sampled only on push; a value of 0 is a legal word (nop) and is queued normally.
- Reset asserted mid-operation: all state cleared immediately; in-flight entries lost.

Optional Feature:
- Macro: FETCH_JUMP_PREDECODE_EN.
- Defined: on push, if imem_data[31:26]==6'b000010 (J):
  - pc <= {pc_plus4[31:28], imem_data[25:0], 2'b00}.
  - The J word is still queued with its own pc.
  - A simultaneous redirect overrides this.
- Not defined: fetch is strictly sequential (pc+4); J is resolved downstream via redirect.

Test Plan:
- Reset, then out_ready=1, memory holds words at 0..16 -> out_pc 0,4,8,12,16 on consecutive cycles; out_valid first high after edge 1; out_pc_plus4 = out_pc+4.
- out_ready=0 for 5 cycles after reset -> count reaches 2, imem_addr holds 8, out_pc holds 0; release -> out_pc 0,4,8 with no gaps or duplicates.
- Queue holding pc 4,8; redirect_valid=1, target 0x40 -> next cycle out_valid=0, imem_addr=0x40; cycle after out_pc=0x40; entries 4,8 never appear.
- Redirect target 0x42 -> out_pc=0x40, misalign_fault=1 and stays 1 through further redirects until rst_n=0.
- RESET_PC=32'hFFFFFFFC -> out_pc FFFFFFFC then 00000000.
- Word {6'b000010, 26'd1} at address 16:
  - Macro defined: out_pc 16 then 4.
  - Macro undefined: out_pc 16 then 20.
